// File: rtl/alu_acc_sequencer_if.sv
// Command channel between a command source and alu_acc_sequencer.
//   cmd_valid : source has a command
//   cmd_ready : sequencer can accept a command this cycle
//   cmd_op    : opcode (LOAD/ADD/SUB/INC/CMP/MUL/CLR/reserved)
//   cmd_data  : operand byte
interface alu_acc_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/alu_acc_sequencer.sv
// Command sequencer and accumulator in front of an external 8-bit
// add/sub/inc/pass stage. Drives the stage operands, captures its result
// into ACC and {Z,N,C,V}, and runs MUL as repeated additions.
//   clk, rst      : clock, synchronous active-high reset
//   cmd_if        : valid/ready command channel (slave side)
//   alu_a_o/b_o   : stage operands A/B
//   alu_s_o       : stage select (00 A+B, 01 A-B, 10 A+1, 11 A+0)
//   alu_out_i     : stage result
//   alu_c_out_i   : stage carry out
//   acc_o         : accumulator
//   flags_o       : {Z,N,C,V}
//   done_o        : one-cycle pulse when the result is visible
//   err_o         : pulses with done_o for the reserved opcode
module alu_acc_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_acc_sequencer_if.slave cmd_if,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [1:0]       alu_s_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_c_out_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [3:0]       flags_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_SUB  = 2'b01;
  localparam logic [1:0] SEL_INC  = 2'b10;
  localparam logic [1:0] SEL_PASS = 2'b11;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] acc_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] cnt_q;
  logic             cf_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       alu_s_q;

  logic [WIDTH-1:0] acc_d;
  logic [3:0]       flags_d;

  // Stage select for a single-cycle op
  function automatic logic [1:0] op_sel(input logic [2:0] op);
    case (op)
      OP_ADD:         return SEL_ADD;
      OP_SUB, OP_CMP: return SEL_SUB;
      OP_INC:         return SEL_INC;
      default:        return SEL_PASS;
    endcase
  endfunction

  assign cmd_if.cmd_ready = (state_q == S_IDLE) && !rst;

  assign alu_a_o = alu_a_q;
  assign alu_b_o = alu_b_q;
  assign alu_s_o = alu_s_q;
  assign acc_o   = acc_q;
  assign flags_o = flags_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

  // Result of the EXEC cycle; stage operands are held in alu_a_q/alu_b_q
  always_comb begin
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;
    res   = acc_q;
    c     = 1'b0;
    v     = 1'b0;
    a_msb = alu_a_q[WIDTH-1];
    b_msb = alu_b_q[WIDTH-1];
    r_msb = alu_out_i[WIDTH-1];
    case (op_q)
      OP_LOAD: res = d_q;
      OP_ADD: begin
        res = alu_out_i;
        c   = alu_c_out_i;
        v   = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB, OP_CMP: begin
        res = alu_out_i;
        c   = alu_c_out_i;
        v   = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_INC: begin
        res = alu_out_i;
        c   = alu_c_out_i;
        v   = (alu_a_q == MAX_POS);
      end
      OP_CLR: res = '0;
      default: res = acc_q;
    endcase
    flags_d = {(res == '0), res[WIDTH-1], c, v};
    acc_d   = (op_q == OP_CMP) ? acc_q : res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      d_q     <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      p_q     <= '0;
      cnt_q   <= '0;
      cf_q    <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_s_q <= SEL_PASS;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // cmd_ready is high whenever IDLE and out of reset
          if (cmd_if.cmd_valid) begin
            op_q <= cmd_if.cmd_op;
            d_q  <= cmd_if.cmd_data;
            if (cmd_if.cmd_op == OP_MUL) begin
              // alu_b_q holds the multiplicand (ACC at accept) for the whole MUL
              state_q <= S_MUL;
              p_q     <= '0;
              cnt_q   <= cmd_if.cmd_data;
              cf_q    <= 1'b0;
              alu_a_q <= '0;
              alu_b_q <= acc_q;
              alu_s_q <= SEL_ADD;
            end else begin
              state_q <= S_EXEC;
              alu_a_q <= acc_q;
              alu_b_q <= cmd_if.cmd_data;
              alu_s_q <= op_sel(cmd_if.cmd_op);
            end
          end
        end
        S_EXEC: begin
          if (op_q != OP_RSV) begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
          end
          done_q  <= 1'b1;
          err_q   <= (op_q == OP_RSV);
          state_q <= S_DONE;
          alu_a_q <= '0;
          alu_b_q <= '0;
          alu_s_q <= SEL_PASS;
        end
        S_MUL: begin
          if (cnt_q != '0) begin
            // P accumulates; alu_a_q tracks P so the stage sees the new sum
            p_q     <= alu_out_i;
            alu_a_q <= alu_out_i;
            cnt_q   <= cnt_q - WIDTH'(1);
            cf_q    <= cf_q | alu_c_out_i;
          end else begin
            acc_q   <= p_q;
            flags_q <= {(p_q == '0), p_q[WIDTH-1], cf_q, 1'b0};
            done_q  <= 1'b1;
            state_q <= S_DONE;
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_s_q <= SEL_PASS;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Self-checking bench for alu_acc_sequencer with a behavioural 8-bit stage.
module tb_alu_acc_sequencer;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic       clk;
  logic       rst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_s;
  logic [7:0] alu_out;
  logic       alu_c_out;
  logic [7:0] acc;
  logic [3:0] flags;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  alu_acc_sequencer_if #(.WIDTH(8)) cmd_if ();

  alu_acc_sequencer #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_if      (cmd_if),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_s_o     (alu_s),
    .alu_out_i   (alu_out),
    .alu_c_out_i (alu_c_out),
    .acc_o       (acc),
    .flags_o     (flags),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream arithmetic stage
  always_comb begin
    logic [8:0] t;
    case (alu_s)
      2'b00:   t = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      2'b10:   t = {1'b0, alu_a} + 9'd1;
      default: t = {1'b0, alu_a};
    endcase
    alu_out   = t[7:0];
    alu_c_out = t[8];
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: apply one command to the architectural state with plain arithmetic
  function automatic void model(input logic [2:0] op, input logic [7:0] b8,
                                inout logic [7:0] acc8, inout logic [3:0] flg,
                                output logic err_e, output int lat);
    int a, b, sa, sb, r, full;
    logic c, v, upd, keep;
    a = int'(acc8);
    b = int'(b8);
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = a; c = 1'b0; v = 1'b0; upd = 1'b1; keep = 1'b0;
    err_e = 1'b0; lat = 2;
    case (op)
      OP_LOAD: r = b;
      OP_ADD: begin
        full = a + b; r = full % 256; c = (full > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      OP_SUB, OP_CMP: begin
        r = (a - b + 256) % 256; c = (a >= b);
        v = (sa - sb > 127) || (sa - sb < -128);
        keep = (op == OP_CMP);
      end
      OP_INC: begin
        r = (a + 1) % 256; c = (a == 255); v = (a == 127);
      end
      OP_MUL: begin
        full = a * b; r = full % 256; c = (full > 255); lat = b + 2;
      end
      OP_CLR: r = 0;
      default: begin upd = 1'b0; err_e = 1'b1; end
    endcase
    if (upd) begin
      flg = {(r == 0), (r > 127), c, v};
      if (!keep) acc8 = 8'(r);
    end
  endfunction

  // Issue one command; returns state captured on the done cycle and accept-to-done latency
  task automatic send(input logic [2:0] op, input logic [7:0] data,
                      output logic [7:0] acc_s, output logic [3:0] flg_s,
                      output logic err_s, output int lat);
    int guard;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    guard = 0;
    while (!cmd_if.cmd_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    acc_s = acc; flg_s = flags; err_s = err;
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] acc;
    logic [3:0] flg;
    logic       err;
    int         lat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [7:0] g_acc, m_acc;
    logic [3:0] g_flg, m_flg;
    logic       g_err, m_err;
    int         g_lat, m_lat;
    int         n_acc, n_done, d_cyc[2];
    logic [7:0] d_acc[2];
    logic [2:0] rop;
    logic [7:0] rdata;

    tbl[0]  = '{OP_LOAD, 8'h7F, 8'h7F, 4'b0000, 1'b0, 2};
    tbl[1]  = '{OP_ADD,  8'h01, 8'h80, 4'b0101, 1'b0, 2};
    tbl[2]  = '{OP_LOAD, 8'h05, 8'h05, 4'b0000, 1'b0, 2};
    tbl[3]  = '{OP_SUB,  8'h05, 8'h00, 4'b1010, 1'b0, 2};
    tbl[4]  = '{OP_CMP,  8'h06, 8'h00, 4'b0100, 1'b0, 2};
    tbl[5]  = '{OP_LOAD, 8'h0D, 8'h0D, 4'b0000, 1'b0, 2};
    tbl[6]  = '{OP_MUL,  8'h05, 8'h41, 4'b0000, 1'b0, 7};
    tbl[7]  = '{OP_LOAD, 8'h20, 8'h20, 4'b0000, 1'b0, 2};
    tbl[8]  = '{OP_MUL,  8'h10, 8'h00, 4'b1010, 1'b0, 18};
    tbl[9]  = '{OP_LOAD, 8'h33, 8'h33, 4'b0000, 1'b0, 2};
    tbl[10] = '{OP_MUL,  8'h00, 8'h00, 4'b1000, 1'b0, 2};
    tbl[11] = '{OP_LOAD, 8'h7F, 8'h7F, 4'b0000, 1'b0, 2};
    tbl[12] = '{OP_INC,  8'h00, 8'h80, 4'b0101, 1'b0, 2};
    tbl[13] = '{OP_CLR,  8'h00, 8'h00, 4'b1000, 1'b0, 2};
    tbl[14] = '{OP_RSV,  8'h55, 8'h00, 4'b1000, 1'b1, 2};
    tbl[15] = '{OP_LOAD, 8'h80, 8'h80, 4'b0100, 1'b0, 2};
    tbl[16] = '{OP_SUB,  8'h01, 8'h7F, 4'b0011, 1'b0, 2};

    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", int'(acc), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(cmd_if.cmd_ready), 0);
    chk("rst_alu_s", int'(alu_s), 3);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(cmd_if.cmd_ready), 1);

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].op, tbl[i].data, g_acc, g_flg, g_err, g_lat);
      chk($sformatf("vec%0d_acc", i), int'(g_acc), int'(tbl[i].acc));
      chk($sformatf("vec%0d_flags", i), int'(g_flg), int'(tbl[i].flg));
      chk($sformatf("vec%0d_err", i), int'(g_err), int'(tbl[i].err));
      chk($sformatf("vec%0d_lat", i), g_lat, tbl[i].lat);
    end

    // Handshake: cmd_valid held through a MUL with churning op/data
    send(OP_LOAD, 8'h0D, g_acc, g_flg, g_err, g_lat);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_MUL;
    cmd_if.cmd_data  = 8'h05;
    n_acc = 0; n_done = 0;
    d_cyc[0] = -1; d_cyc[1] = -1; d_acc[0] = 8'h00; d_acc[1] = 8'h00;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) n_acc++;
      @(posedge clk); #1;
      if (done) begin
        if (n_done < 2) begin d_cyc[n_done] = cyc; d_acc[n_done] = acc; end
        n_done++;
      end
      if (n_acc == 1) begin
        if (cmd_if.cmd_ready) begin
          cmd_if.cmd_op = OP_LOAD; cmd_if.cmd_data = 8'h5A;
        end else begin
          cmd_if.cmd_op = 3'($urandom_range(0, 6)); cmd_if.cmd_data = 8'($urandom);
        end
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
    end
    chk("hs_accepts", n_acc, 2);
    chk("hs_dones", n_done, 2);
    chk("hs_mul_done_cyc", d_cyc[0], 6);
    chk("hs_mul_acc", int'(d_acc[0]), 8'h41);
    chk("hs_load_done_cyc", d_cyc[1], 9);
    chk("hs_load_acc", int'(d_acc[1]), 8'h5A);

    // Reset on the 3rd MUL cycle
    send(OP_LOAD, 8'h0D, g_acc, g_flg, g_err, g_lat);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_MUL;
    cmd_if.cmd_data  = 8'h05;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", int'(cmd_if.cmd_ready), 0);
    @(posedge clk); #1;
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_flags", int'(flags), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", int'(cmd_if.cmd_ready), 1);
    n_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);

    // Random commands against the reference model
    m_acc = 8'h00; m_flg = 4'h0;
    for (int i = 0; i < 150; i++) begin
      rop   = 3'($urandom_range(0, 7));
      rdata = (rop == OP_MUL) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      model(rop, rdata, m_acc, m_flg, m_err, m_lat);
      send(rop, rdata, g_acc, g_flg, g_err, g_lat);
      chk($sformatf("rnd%0d_op%0d_acc", i, rop), int'(g_acc), int'(m_acc));
      chk($sformatf("rnd%0d_op%0d_flags", i, rop), int'(g_flg), int'(m_flg));
      chk($sformatf("rnd%0d_op%0d_err", i, rop), int'(g_err), int'(m_err));
      chk($sformatf("rnd%0d_op%0d_lat", i, rop), g_lat, m_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
Command sequencer and accumulator that sits directly upstream of the 8-bit arithmetic stage (add/sub/inc/pass unit). It accepts byte commands over a valid/ready handshake and drives the stage's A/B/S operand inputs. It captures the stage's result and carry into an accumulator register and a ZNCV flag register. It also implements a multi-cycle MUL by iterating repeated additions through the stage.

Parameters:
WIDTH, 8, datapath width of ACC, operands and stage interface; the test plan uses 8.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  opcode: 000 LOAD, 001 ADD, 010 SUB, 011 INC, 100 CMP, 101 MUL, 110 CLR, 111 reserved
cmd_data  input  WIDTH  operand byte
alu_a  output  WIDTH  to stage input A
alu_b  output  WIDTH  to stage input B
alu_s  output  2  to stage select: 00 A+B, 01 A-B, 10 A+1, 11 A+0
alu_out  input  WIDTH  stage result
alu_c_out  input  1  stage carry out
acc  output  WIDTH  accumulator
flags  output  4  {Z,N,C,V}
done  output  1  one-cycle pulse when the command's result is visible on acc/flags
err  output  1  one-cycle pulse with done for the reserved opcode

Behaviour:
- Reset (rst=1 at posedge): state IDLE; acc=0, flags=0, done=0, err=0, internal P/count=0. cmd_ready=0 while rst is high. Reset mid-command abandons the command with no partial acc update.
- States: IDLE, EXEC, MUL, DONE. cmd_ready=1 only in IDLE and not in reset.
- Accept: cmd_valid&cmd_ready at cycle T latches op/data into OP/D and moves to EXEC. MUL instead goes to MUL with P=0, CNT=D, MC=acc.
- EXEC (one cycle): alu_a=acc, alu_b=D. alu_s is 00 for ADD, 01 for SUB/CMP, 10 for INC, 11 otherwise. Registers update at the edge ending EXEC; the next state is DONE.
- DONE (one cycle): done=1. Next state is IDLE, so cmd_ready returns at T+3. Single-cycle op latency is accept edge to done = 2 cycles.
- LOAD: acc=D; Z,N from D; C=V=0.
- ADD/SUB/INC: acc=alu_out; C=alu_c_out. For SUB, C=1 means no borrow.
- CMP: same as SUB, but flags update and acc is unchanged.
- CLR: acc=0; flags=1000.
- Reserved: acc and flags unchanged; err=1 together with done.
- Z=(result==0); N=result[WIDTH-1]. V is computed locally from the operands a, b and result r:
  - ADD: (a.msb==b.msb)&&(r.msb!=a.msb)
  - SUB/CMP: (a.msb!=b.msb)&&(r.msb!=a.msb)
  - INC: a==0111..1
- MUL state: alu_a=P, alu_b=MC, alu_s=00. Each cycle with CNT!=0: P<=alu_out; CNT<=CNT-1; CF<=CF|alu_c_out.
  - When CNT==0: acc<=P; Z,N from P; C=CF; V=0; next state DONE.
  - MUL therefore spends D+1 cycles in MUL, with a minimum of 1 when D=0 (result 0, Z=1).
  - Product is truncated to WIDTH bits; C=1 flags unsigned product overflow.
- cmd_valid may be held while busy and is ignored until cmd_ready=1. cmd_op/cmd_data are sampled only at acceptance, so changes while busy have no effect.
- alu_a/alu_b/alu_s are don't-care in IDLE/DONE and are driven 0/0/11.

Test Plan:
1. Signed-overflow add: reset, LOAD 0x7F, ADD 0x01 -> acc=0x80, flags Z0 N1 C0 V1. done arrives exactly 2 cycles after each accept.
2. Subtract and compare: LOAD 0x05, SUB 0x05 -> acc=0x00, Z1 N0 C1 V0. Then CMP 0x06 -> acc stays 0x00, N1 C0 Z0.
3. Multiply: LOAD 0x0D, MUL 0x05 -> 6 cycles in MUL, then acc=0x41, C0. LOAD 0x20, MUL 0x10 -> acc=0x00, Z1 C1. LOAD 0x33, MUL 0x00 -> acc=0x00, Z1, 1 MUL cycle.
4. Handshake: hold cmd_valid high with changing ops during a MUL -> only the first command executes. The next command is accepted the cycle cmd_ready rises; no command is lost or duplicated.
5. Reset mid-MUL: LOAD 0x0D, MUL 0x05, assert rst on the 3rd MUL cycle -> acc=0, flags=0, no done. IDLE with cmd_ready=1 the cycle after rst drops.
6. INC/CLR/reserved: LOAD 0x7F, INC -> acc=0x80, V1. CLR -> acc=0, flags=1000. Op 111 -> done and err pulse together, acc/flags unchanged.
